// File: rtl/fp_to_int_pkg.sv
// Shared FPU definitions: binary32 field layout, rounding-mode codes,
// integer saturation constants and operand classification.
package fp_to_int_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned BIAS   = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

   // binary32 encoding of exactly -2^31, the only E = 31 value that fits a signed int
   localparam logic [31:0] F32_NEG_2P31 = 32'hCF00_0000;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rm_e;

   typedef enum logic [1:0] {
      CLS_NUM,
      CLS_ZERO,
      CLS_NAN,
      CLS_SAT
   } cls_e;

   // Result for NaN and for saturating (infinite or out-of-range) operands
   function automatic logic [31:0] sat_value(input logic uns, input logic sign, input cls_e cls);
      logic [31:0] v;
      if (cls == CLS_NAN) begin
         v = uns ? UINT_MAX : INT_MAX;
      end else if (uns) begin
         v = sign ? '0 : UINT_MAX;
      end else begin
         v = sign ? INT_MIN : INT_MAX;
      end
      return v;
   endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Rounding-increment decision shared by FPU conversion and arithmetic units.
// Unknown rounding-mode codes round toward zero.
module fp_round_inc
   import fp_to_int_pkg::*;
(
   input  logic [2:0] i_rm,
   input  logic       i_sign,
   input  logic       i_lsb,
   input  logic       i_guard,
   input  logic       i_sticky,
   output logic       o_inc
);

   // Pick the increment according to the rounding mode
   always_comb begin
      o_inc = 1'b0;
      case (i_rm)
         RM_RNE:  o_inc = i_guard & (i_sticky | i_lsb);
         RM_RTZ:  o_inc = 1'b0;
         RM_RDN:  o_inc = i_sign & (i_guard | i_sticky);
         RM_RUP:  o_inc = ~i_sign & (i_guard | i_sticky);
         RM_RMM:  o_inc = i_guard;
         default: o_inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_to_int.sv
// Three-stage binary32 -> int32/uint32 converter (fcvt.w.s / fcvt.wu.s)
// with RISC-V saturation, NV/NX flags and a global valid/ready stall.
module fp_to_int
   import fp_to_int_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic        in_unsigned,
   input  logic [2:0]  in_rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_int,
   output logic        out_nv,
   output logic        out_nx
);

   // ---------------- stage 1: decompose, classify, shift amount ----------------
   logic              w_sign;
   logic [EXP_W-1:0]  w_exp;
   logic [FRAC_W-1:0] w_frac;
   logic signed [8:0] w_e_unb;
   cls_e              w_cls;
   logic              w_small;
   logic              w_small_g;
   logic              w_small_st;

   logic              r1_valid;
   logic              r1_sign;
   logic              r1_uns;
   logic [2:0]        r1_rm;
   cls_e              r1_cls;
   logic              r1_small;
   logic              r1_small_g;
   logic              r1_small_st;
   logic [FRAC_W:0]   r1_mant;
   logic [5:0]        r1_shamt;

   // ---------------- stage 2: barrel shift, guard/sticky ----------------
   logic [63:0]       w_wide;
   logic [31:0]       w_mag;
   logic              w_g;
   logic              w_st;

   logic              r2_valid;
   logic              r2_sign;
   logic              r2_uns;
   logic [2:0]        r2_rm;
   cls_e              r2_cls;
   logic [31:0]       r2_mag;
   logic              r2_g;
   logic              r2_st;

   // ---------------- stage 3: round, negate, saturate ----------------
   logic              w_inc;
   logic [31:0]       w_mag_rnd;
   logic [31:0]       w_res;
   logic              w_nv;
   logic              w_nx;

   logic              r3_valid;
   logic [31:0]       r3_int;
   logic              r3_nv;
   logic              r3_nx;

   logic              w_adv;

   assign w_adv     = ~(r3_valid & ~out_ready);
   assign in_ready  = w_adv;
   assign out_valid = r3_valid;
   assign out_int   = r3_int;
   assign out_nv    = r3_nv;
   assign out_nx    = r3_nx;

   assign w_sign  = in_a[31];
   assign w_exp   = in_a[FRAC_W +: EXP_W];
   assign w_frac  = in_a[FRAC_W-1:0];
   assign w_e_unb = 9'({1'b0, w_exp}) - 9'(BIAS);

   // Classify the operand; values below 1.0 skip the shifter with precomputed guard/sticky
   always_comb begin
      w_cls      = CLS_NUM;
      w_small    = 1'b0;
      w_small_g  = 1'b0;
      w_small_st = 1'b0;
      if (w_exp == EXP_MAX) begin
         if (w_frac != '0) begin
            w_cls = CLS_NAN;
         end else begin
            w_cls = CLS_SAT;
         end
      end else if (w_exp == '0) begin
         if (w_frac == '0) begin
            w_cls = CLS_ZERO;
         end else begin
            w_small    = 1'b1;
            w_small_st = 1'b1;
         end
      end else if (w_e_unb < 9'sd0) begin
         w_small    = 1'b1;
         w_small_g  = (w_e_unb == -9'sd1);
         w_small_st = (w_e_unb != -9'sd1) | (|w_frac);
      end else if (in_unsigned) begin
         if (w_e_unb >= 9'sd32) begin
            w_cls = CLS_SAT;
         end
      end else if ((w_e_unb >= 9'sd31) && (in_a != F32_NEG_2P31)) begin
         w_cls = CLS_SAT;
      end
   end

   // Stage 1 register; shift amount places 1.f into a Q32.32 word (E + 9)
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid    <= 1'b0;
         r1_sign     <= 1'b0;
         r1_uns      <= 1'b0;
         r1_rm       <= '0;
         r1_cls      <= CLS_ZERO;
         r1_small    <= 1'b0;
         r1_small_g  <= 1'b0;
         r1_small_st <= 1'b0;
         r1_mant     <= '0;
         r1_shamt    <= '0;
      end else if (w_adv) begin
         r1_valid    <= in_valid;
         r1_sign     <= w_sign;
         r1_uns      <= in_unsigned;
         r1_rm       <= in_rm;
         r1_cls      <= w_cls;
         r1_small    <= w_small;
         r1_small_g  <= w_small_g;
         r1_small_st <= w_small_st;
         r1_mant     <= {1'b1, w_frac};
         r1_shamt    <= w_e_unb[5:0] + 6'd9;
      end
   end

   // Align the mantissa: integer part in [63:32], guard at 31, sticky below
   always_comb begin
      w_wide = {40'd0, r1_mant} << r1_shamt;
      w_mag  = w_wide[63:32];
      w_g    = w_wide[31];
      w_st   = |w_wide[30:0];
      if (r1_small) begin
         w_mag = '0;
         w_g   = r1_small_g;
         w_st  = r1_small_st;
      end
   end

   // Stage 2 register
   always_ff @(posedge clk) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_sign  <= 1'b0;
         r2_uns   <= 1'b0;
         r2_rm    <= '0;
         r2_cls   <= CLS_ZERO;
         r2_mag   <= '0;
         r2_g     <= 1'b0;
         r2_st    <= 1'b0;
      end else if (w_adv) begin
         r2_valid <= r1_valid;
         r2_sign  <= r1_sign;
         r2_uns   <= r1_uns;
         r2_rm    <= r1_rm;
         r2_cls   <= r1_cls;
         r2_mag   <= w_mag;
         r2_g     <= w_g;
         r2_st    <= w_st;
      end
   end

   fp_round_inc u_round_inc (
      .i_rm     (r2_rm),
      .i_sign   (r2_sign),
      .i_lsb    (r2_mag[0]),
      .i_guard  (r2_g),
      .i_sticky (r2_st),
      .o_inc    (w_inc)
   );

   // Round, apply sign, and resolve saturation and flags
   always_comb begin
      w_res     = '0;
      w_nv      = 1'b0;
      w_nx      = 1'b0;
      w_mag_rnd = r2_mag + {31'd0, w_inc};
      case (r2_cls)
         CLS_NAN, CLS_SAT: begin
            w_res = sat_value(r2_uns, r2_sign, r2_cls);
            w_nv  = 1'b1;
         end
         CLS_ZERO: begin
            w_res = '0;
         end
         default: begin
            if (r2_uns && r2_sign) begin
               // negative to unsigned: only a value that rounds to zero is representable
               if (w_mag_rnd != '0) begin
                  w_nv = 1'b1;
               end else begin
                  w_nx = r2_g | r2_st;
               end
            end else begin
               w_nx  = r2_g | r2_st;
               w_res = r2_sign ? (~w_mag_rnd + 32'd1) : w_mag_rnd;
            end
         end
      endcase
   end

   // Stage 3 / output register, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         r3_valid <= 1'b0;
         r3_int   <= '0;
         r3_nv    <= 1'b0;
         r3_nx    <= 1'b0;
      end else if (w_adv) begin
         r3_valid <= r2_valid;
         r3_int   <= w_res;
         r3_nv    <= w_nv;
         r3_nx    <= w_nx;
      end
   end

endmodule

// File: tb/tb_fp_to_int.sv
// Self-checking bench for fp_to_int: directed corner cases, handshake
// stall, mid-flight reset and randomized traffic against a real-number model.
module tb_fp_to_int;

   typedef struct packed {
      logic [31:0] v;
      logic        nv;
      logic        nx;
   } exp_t;

   typedef struct packed {
      logic [31:0] a;
      logic        uns;
      logic [2:0]  rm;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic        in_unsigned;
   logic [2:0]  in_rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_int;
   logic        out_nv;
   logic        out_nx;

   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    acc_cyc = 0;
   int    out_cyc = 0;
   bit    consumed = 1'b0;
   bit    hold_chk = 1'b0;
   exp_t  held;
   exp_t  exp_q[$];
   stim_t stim_q[$];

   fp_to_int dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_unsigned (in_unsigned),
      .in_rm       (in_rm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_int     (out_int),
      .out_nv      (out_nv),
      .out_nx      (out_nx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic real pow2(input int n);
      real p;
      p = 1.0;
      if (n >= 0) begin
         for (int i = 0; i < n; i++) p = p * 2.0;
      end else begin
         for (int i = 0; i < -n; i++) p = p / 2.0;
      end
      return p;
   endfunction

   // Reference: exact real value, rounded by mode, then range-checked
   function automatic exp_t model(input logic [31:0] a, input logic uns, input logic [2:0] rm);
      exp_t        r;
      real         v, fl, fr, q;
      int unsigned e, mi;
      longint      li;
      bit          up;
      r.v  = '0;
      r.nv = 1'b0;
      r.nx = 1'b0;
      e = a[30:23];
      if (e == 255) begin
         r.nv = 1'b1;
         if (a[22:0] != 0)  r.v = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         else if (uns)      r.v = a[31] ? 32'h0 : 32'hFFFF_FFFF;
         else               r.v = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         return r;
      end
      if (e == 0) begin
         mi = a[22:0];
         v  = mi * pow2(-149);
      end else begin
         mi = {1'b1, a[22:0]};
         v  = mi * pow2(int'(e) - 150);
      end
      if (a[31]) v = -v;
      fl = $floor(v);
      fr = v - fl;
      up = 1'b0;
      case (rm)
         3'd0: begin
            if (fr > 0.5) up = 1'b1;
            else if (fr == 0.5) begin
               li = longint'(fl);
               up = li[0];
            end
         end
         3'd2: up = 1'b0;
         3'd3: up = (fr > 0.0);
         3'd4: up = (fr > 0.5) || (fr == 0.5 && v > 0.0);
         default: up = (v < 0.0) && (fr > 0.0);
      endcase
      q = up ? fl + 1.0 : fl;
      if (uns) begin
         if (q < 0.0) begin
            r.nv = 1'b1;
         end else if (q > 4294967295.0) begin
            r.v  = 32'hFFFF_FFFF;
            r.nv = 1'b1;
         end else begin
            li   = longint'(q);
            r.v  = li[31:0];
            r.nx = (q != v);
         end
      end else begin
         if (q < -2147483648.0) begin
            r.v  = 32'h8000_0000;
            r.nv = 1'b1;
         end else if (q > 2147483647.0) begin
            r.v  = 32'h7FFF_FFFF;
            r.nv = 1'b1;
         end else begin
            li   = longint'(q);
            r.v  = li[31:0];
            r.nx = (q != v);
         end
      end
      return r;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      logic  sg;
      sg = 1'($urandom);
      case ($urandom_range(0, 3))
         0: s.a = $urandom;
         1: s.a = {sg, 8'($urandom_range(110, 160)), 23'($urandom)};
         2: s.a = {sg, 8'($urandom_range(154, 159)), 23'($urandom)};
         default: begin
            case ($urandom_range(0, 9))
               0: s.a = 32'h0000_0000;
               1: s.a = 32'h8000_0000;
               2: s.a = 32'h7F80_0000;
               3: s.a = 32'hFF80_0000;
               4: s.a = 32'h7FC0_0001;
               5: s.a = 32'hCF00_0000;
               6: s.a = 32'h4F7F_FFFF;
               7: s.a = {sg, 8'd0, 23'($urandom)};
               8: s.a = {sg, 8'd126, 23'($urandom_range(0, 3))};
               default: s.a = {sg, 8'($urandom_range(127, 130)), 2'($urandom), 21'd0};
            endcase
         end
      endcase
      s.uns = 1'($urandom);
      s.rm  = 3'($urandom);
      return s;
   endfunction

   // One clock of traffic: check last stall, drive inputs, score transfers
   task automatic step(input bit allow_in, input bit rdy);
      exp_t  e;
      stim_t s;
      @(negedge clk);
      cyc++;
      if (hold_chk) begin
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_int", out_int, held.v);
         check_eq("hold_nv", out_nv, held.nv);
         check_eq("hold_nx", out_nx, held.nx);
      end
      if (consumed) begin
         in_valid = 1'b0;
         consumed = 1'b0;
      end
      out_ready = rdy;
      if (!in_valid && allow_in && stim_q.size() != 0) begin
         s           = stim_q.pop_front();
         in_a        = s.a;
         in_unsigned = s.uns;
         in_rm       = s.rm;
         in_valid    = 1'b1;
      end
      #1;
      hold_chk = out_valid && !out_ready;
      if (hold_chk) begin
         check_eq("stall_in_ready", in_ready, 0);
         held.v  = out_int;
         held.nv = out_nv;
         held.nx = out_nx;
      end else begin
         check_eq("in_ready", in_ready, 1);
      end
      if (out_valid && out_ready) begin
         out_cyc = cyc;
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", out_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("out_int", out_int, e.v);
            check_eq("out_nv", out_nv, e.nv);
            check_eq("out_nx", out_nx, e.nx);
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(in_a, in_unsigned, in_rm));
         consumed = 1'b1;
         acc_cyc  = cyc;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (exp_q.size() != 0 || stim_q.size() != 0 || in_valid); i++) begin
         step(1'b1, 1'b1);
      end
      check_eq("drain_left", exp_q.size(), 0);
   endtask

   task automatic push(input logic [31:0] a, input logic uns, input logic [2:0] rm);
      stim_t s;
      s.a   = a;
      s.uns = uns;
      s.rm  = rm;
      stim_q.push_back(s);
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_a        = '0;
      in_unsigned = 1'b0;
      in_rm       = '0;
      out_ready   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_int", out_int, 0);
      check_eq("rst_out_nv", out_nv, 0);
      check_eq("rst_out_nx", out_nx, 0);
      rst = 1'b0;

      // directed corner cases (a, unsigned, rm)
      push(32'h3FC0_0000, 1'b0, 3'd0);
      push(32'h4020_0000, 1'b0, 3'd0);
      push(32'h4020_0000, 1'b0, 3'd4);
      push(32'hBFC0_0000, 1'b0, 3'd1);
      push(32'hBFC0_0000, 1'b0, 3'd2);
      push(32'h7FC0_0000, 1'b0, 3'd0);
      push(32'h7FC0_0000, 1'b1, 3'd0);
      push(32'h4F00_0000, 1'b0, 3'd0);
      push(32'hCF00_0000, 1'b0, 3'd0);
      push(32'hFF80_0000, 1'b0, 3'd0);
      push(32'hBF80_0000, 1'b1, 3'd0);
      push(32'hBE99_999A, 1'b1, 3'd1);
      push(32'h0000_0001, 1'b1, 3'd3);
      push(32'h4F80_0000, 1'b1, 3'd0);
      push(32'h4F7F_FFFF, 1'b1, 3'd0);
      push(32'h3F00_0000, 1'b0, 3'd0);
      push(32'hBF20_0000, 1'b0, 3'd7);
      push(32'h8000_0000, 1'b1, 3'd2);
      drain();

      // single-operand latency
      out_cyc = 0;
      push(32'h42F6_0000, 1'b0, 3'd0);
      drain();
      check_eq("latency", out_cyc - acc_cyc, 3);

      // six back-to-back with out_ready low on cycles 4..6
      for (int i = 0; i < 6; i++) push(32'h4100_0000 + 32'(i) * 32'h0008_0000, 1'b0, 3'd0);
      for (int i = 1; i <= 14; i++) step(1'b1, !(i >= 4 && i <= 6));
      drain();

      // reset with three operands in flight
      for (int i = 0; i < 3; i++) stim_q.push_back(rand_stim());
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_in_ready", in_ready, 1);
      check_eq("midrst_out_int", out_int, 0);
      exp_q.delete();
      stim_q.delete();
      consumed = 1'b0;
      hold_chk = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

      // randomized traffic with random bubbles and backpressure
      for (int i = 0; i < 600; i++) stim_q.push_back(rand_stim());
      for (int i = 0; i < 1500 && stim_q.size() != 0; i++) begin
         step($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
